// File: rtl/nanov_spi_mem_master_if.sv
// Request/response bundle between the nanoV load/store/fetch logic and the
// SPI memory master. The core side uses the master modport; the SPI engine
// uses the slave modport.
interface nanov_spi_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/nanov_spi_mem_master.sv
// SPI RAM master for nanoV: turns one parallel read/write request into a full
// SPI transaction (select, opcode, 24-bit address, data bytes, deselect) and
// returns a single-cycle response. Every output is a flop; the next output
// values are derived from the next FSM state so pins change on clock edges only.
module nanov_spi_mem_master #(
    parameter int         DATA_BYTES = 4,
    parameter logic [7:0] CMD_READ   = 8'h03,
    parameter logic [7:0] CMD_WRITE  = 8'h02
) (
    input  logic                         clk,
    input  logic                         rst,
    nanov_spi_mem_master_if.slave        bus,
    input  logic                         spi_data_in,
    output logic                         spi_select,
    output logic                         spi_out,
    output logic                         spi_clk_enable
);
    localparam int DW = 8 * DATA_BYTES;   // data bits per transaction
    localparam int FW = 32 + DW;          // opcode + address + data bits on MOSI

    localparam logic [5:0] CMD_LAST  = 6'd7;
    localparam logic [5:0] ADDR_LAST = 6'd23;
    localparam logic [5:0] DATA_LAST = 6'(DW - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_CMD    = 3'd2,
        S_ADDR   = 3'd3,
        S_DATA   = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [FW-1:0]   tx_q, tx_d;
    logic [DW-1:0]   rx_q, rx_d;
    logic            write_q, write_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            spi_select_q, spi_select_d;
    logic            spi_out_q, spi_out_d;
    logic            spi_clk_enable_q, spi_clk_enable_d;
    logic            shift_s;

    // Bytes travel lowest address first, so byte 0 of the word sits at the
    // MSB end of the wire-order vector that is shifted out MSB first.
    function automatic logic [DW-1:0] to_wire_order(input logic [31:0] word);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            r[DW-1-8*i -: 8] = word[8*i +: 8];
        end
        return r;
    endfunction

    // Inverse of to_wire_order; bits above the transferred bytes stay zero.
    function automatic logic [31:0] from_wire_order(input logic [DW-1:0] bits);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            r[8*i +: 8] = bits[DW-1-8*i -: 8];
        end
        return r;
    endfunction

    // Next-state, phase counter and shift-register datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        write_d = write_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    state_d = S_SELECT;
                    cnt_d   = 6'd0;
                    write_d = bus.req_write;
                    tx_d    = {(bus.req_write ? CMD_WRITE : CMD_READ),
                               bus.req_addr,
                               (bus.req_write ? to_wire_order(bus.req_wdata) : {DW{1'b0}})};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SELECT: begin
                state_d = S_CMD;
                cnt_d   = 6'd0;
                tx_d    = {tx_q[FW-2:0], 1'b0};
            end
            S_CMD: begin
                tx_d = {tx_q[FW-2:0], 1'b0};
                if (cnt_q == CMD_LAST) begin
                    state_d = S_ADDR;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_ADDR: begin
                tx_d = {tx_q[FW-2:0], 1'b0};
                if (cnt_q == ADDR_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DATA: begin
                tx_d = {tx_q[FW-2:0], 1'b0};
                // MISO only matters for reads; writes leave the receive register alone.
                if (!write_q) begin
                    rx_d = {rx_q[DW-2:0], spi_data_in};
                end else begin
                    rx_d = rx_q;
                end
                if (cnt_q == DATA_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // Next values of the registered outputs, taken from the state being entered.
    always_comb begin
        shift_s          = (state_d == S_CMD) || (state_d == S_ADDR) || (state_d == S_DATA);
        req_ready_d      = (state_d == S_IDLE);
        rsp_valid_d      = (state_d == S_DONE);
        spi_select_d     = !(shift_s || (state_d == S_SELECT));
        spi_clk_enable_d = shift_s;
        if (shift_s) begin
            spi_out_d = tx_q[FW-1];
        end else begin
            spi_out_d = 1'b0;
        end
        if (state_d == S_DONE) begin
            rsp_rdata_d = write_q ? 32'h0 : from_wire_order(rx_d);
        end else begin
            rsp_rdata_d = rsp_rdata_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            cnt_q            <= 6'd0;
            tx_q             <= '0;
            rx_q             <= '0;
            write_q          <= 1'b0;
            req_ready_q      <= 1'b0;
            rsp_valid_q      <= 1'b0;
            rsp_rdata_q      <= 32'h0;
            spi_select_q     <= 1'b1;
            spi_out_q        <= 1'b0;
            spi_clk_enable_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            tx_q             <= tx_d;
            rx_q             <= rx_d;
            write_q          <= write_d;
            req_ready_q      <= req_ready_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_rdata_q      <= rsp_rdata_d;
            spi_select_q     <= spi_select_d;
            spi_out_q        <= spi_out_d;
            spi_clk_enable_q <= spi_clk_enable_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign spi_select     = spi_select_q;
    assign spi_out        = spi_out_q;
    assign spi_clk_enable = spi_clk_enable_q;
endmodule

// File: tb/tb_nanov_spi_mem_master.sv
// Bench for nanov_spi_mem_master: a 4-byte and a 1-byte instance, driven with
// directed and random transactions and checked against a transaction-level
// model (expected MOSI bit stream, read word, latency and pin activity).
`timescale 1ns/1ps
module tb_nanov_spi_mem_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        use_small;
    logic        req_valid;
    logic        req_write;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic        miso;
    logic        sel4, out4, ce4, sel1, out1, ce1;
    logic        m_ready, m_rsp, m_sel, m_ce, m_out;
    logic [31:0] m_rdata;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          prev_hold = 1'b0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    nanov_spi_mem_master_if if4 ();
    nanov_spi_mem_master_if if1 ();

    assign if4.req_valid = req_valid & ~use_small;
    assign if4.req_write = req_write;
    assign if4.req_addr  = req_addr;
    assign if4.req_wdata = req_wdata;
    assign if1.req_valid = req_valid & use_small;
    assign if1.req_write = req_write;
    assign if1.req_addr  = req_addr;
    assign if1.req_wdata = req_wdata;

    nanov_spi_mem_master #(.DATA_BYTES(4)) dut4 (
        .clk(clk), .rst(rst), .bus(if4), .spi_data_in(miso),
        .spi_select(sel4), .spi_out(out4), .spi_clk_enable(ce4)
    );

    nanov_spi_mem_master #(.DATA_BYTES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1), .spi_data_in(miso),
        .spi_select(sel1), .spi_out(out1), .spi_clk_enable(ce1)
    );

    assign m_ready = use_small ? if1.req_ready : if4.req_ready;
    assign m_rsp   = use_small ? if1.rsp_valid : if4.rsp_valid;
    assign m_rdata = use_small ? if1.rsp_rdata : if4.rsp_rdata;
    assign m_sel   = use_small ? sel1 : sel4;
    assign m_ce    = use_small ? ce1 : ce4;
    assign m_out   = use_small ? out1 : out4;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction on the selected instance. rst_cyc > 0 aborts it with a
    // one-cycle reset in that cycle; hold keeps req_valid high afterwards.
    task automatic run_txn(input bit wr, input logic [23:0] addr, input logic [31:0] wdata,
                           input logic [31:0] mdata, input int rst_cyc, input bit hold);
        int db, lat, waited, rsp_cyc, n_rsp, n_sck, n_sel_lo, first_lo, n_busy_rdy, n_out_bad;
        logic [63:0] got_s, exp_s;
        logic [31:0] exp_r, got_r;
        logic [7:0]  b;
        bit          gap_ok;

        db  = use_small ? 1 : 4;
        lat = 2 + 8 + 24 + 8 * db;

        // Reference: byte stream opcode, address high..low, data bytes ascending.
        exp_s = 64'h0;
        for (int i = 0; i < 4 + db; i++) begin
            case (i)
                0:       b = wr ? 8'h02 : 8'h03;
                1:       b = addr[23:16];
                2:       b = addr[15:8];
                3:       b = addr[7:0];
                default: b = wr ? wdata[8*(i-4) +: 8] : 8'h00;
            endcase
            for (int k = 7; k >= 0; k--) exp_s = {exp_s[62:0], b[k]};
        end
        exp_r = 32'h0;
        if (!wr) begin
            for (int i = 0; i < db; i++) exp_r[8*i +: 8] = mdata[8*i +: 8];
        end

        waited = 0;
        while (m_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (prev_hold) check_eq("b2b_accept_wait", 64'(waited), 64'd0);
        if (waited >= 200) begin
            check_eq("ready_timeout", 64'(m_ready), 64'd1);
            prev_hold = 1'b0;
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;

        got_s = 64'h0; got_r = 32'h0; rsp_cyc = -1; n_rsp = 0; n_sck = 0; n_sel_lo = 0;
        first_lo = -1; n_busy_rdy = 0; n_out_bad = 0; gap_ok = 1'b1;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = hold;
                req_write = 1'($urandom);
                req_addr  = 24'($urandom);
                req_wdata = $urandom;
            end
            if (c >= 34 && c < 34 + 8 * db) miso = mdata[8*((c-34)/8) + 7 - ((c-34)%8)];
            else                            miso = 1'($urandom);
            if (m_ce) begin
                got_s = {got_s[62:0], m_out};
                n_sck++;
            end else if (m_out) begin
                n_out_bad++;
            end
            if (!m_sel) begin
                n_sel_lo++;
                if (first_lo < 0) first_lo = c;
            end
            if (m_rsp) begin
                n_rsp++;
                rsp_cyc = c;
                got_r   = m_rdata;
            end
            if (c <= lat && m_ready) n_busy_rdy++;
            if (c >= lat && !m_sel) gap_ok = 1'b0;
            if (c == rst_cyc) begin
                rst       = 1'b1;
                req_valid = 1'b0;
                @(negedge clk);
                check_eq("abort_pins", 64'({m_sel, m_ce, m_out, m_rsp}), 64'b1000);
                rst   = 1'b0;
                n_rsp = 0;
                @(negedge clk);
                check_eq("abort_ready", 64'(m_ready), 64'd1);
                for (int j = 0; j < 80; j++) begin
                    if (m_rsp) n_rsp++;
                    @(negedge clk);
                end
                check_eq("abort_no_rsp", 64'(n_rsp), 64'd0);
                prev_hold = 1'b0;
                return;
            end
        end
        check_eq("latency", 64'(rsp_cyc), 64'(lat));
        check_eq("rsp_pulses", 64'(n_rsp), 64'd1);
        check_eq("rdata", 64'(got_r), 64'(exp_r));
        check_eq("mosi_stream", got_s, exp_s);
        check_eq("sck_cycles", 64'(n_sck), 64'(32 + 8 * db));
        check_eq("sel_first_low", 64'(first_lo), 64'd1);
        check_eq("sel_low_cycles", 64'(n_sel_lo), 64'(lat - 1));
        check_eq("ready_while_busy", 64'(n_busy_rdy), 64'd0);
        check_eq("ready_after_done", 64'(m_ready), 64'd1);
        check_eq("sel_gap", 64'(gap_ok), 64'd1);
        check_eq("mosi_quiet", 64'(n_out_bad), 64'd0);
        check_eq("rdata_hold", 64'(m_rdata), 64'(exp_r));
        prev_hold = hold;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Stimulus sequence.
    initial begin
        rst = 1'b1; use_small = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 24'h0; req_wdata = 32'h0; miso = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outs4", 64'({if4.req_ready, if4.rsp_valid, if4.rsp_rdata, sel4, out4, ce4}),
                 64'({1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0}));
        check_eq("reset_outs1", 64'({if1.req_ready, if1.rsp_valid, if1.rsp_rdata, sel1, out1, ce1}),
                 64'({1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0}));
        req_valid = 1'b1;   // rst must win over a simultaneous request
        @(negedge clk);
        check_eq("reset_beats_req", 64'({if4.req_ready, sel4}), 64'b01);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst4", 64'(if4.req_ready), 64'd1);
        check_eq("ready_after_rst1", 64'(if1.req_ready), 64'd1);

        run_txn(1'b0, 24'h000010, 32'h0, 32'h44332211, -1, 1'b0);
        run_txn(1'b1, 24'h00ABCD, 32'h12345678, 32'hFFFFFFFF, -1, 1'b0);
        run_txn(1'b0, 24'($urandom), 32'h0, $urandom, -1, 1'b1);
        run_txn(1'b0, 24'($urandom), 32'h0, $urandom, -1, 1'b0);
        for (int t = 0; t < 6; t++) begin
            run_txn(1'($urandom), 24'($urandom), $urandom, $urandom, -1, 1'b0);
        end
        run_txn(1'b0, 24'h123456, 32'h0, 32'hDEADBEEF, 20, 1'b0);
        run_txn(1'b0, 24'h654321, 32'h0, 32'hCAFEF00D, -1, 1'b0);
        run_txn(1'b0, 24'($urandom), 32'h0, 32'h0, -1, 1'b0);

        use_small = 1'b1;
        run_txn(1'b0, 24'hFFFFFF, 32'h0, 32'h5A5A5AA5, -1, 1'b0);
        run_txn(1'b1, 24'($urandom), $urandom, $urandom, -1, 1'b0);
        run_txn(1'b0, 24'($urandom), 32'h0, $urandom, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
